// File: rtl/univ_shreg_seq_pkg.sv
// Shared encodings for the universal shift register: mode select and FSM states.
package univ_shreg_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Only the two directional modes can launch a multi-bit shift.
  function automatic logic is_shift_mode(input logic [1:0] m);
    return (m == SHR) || (m == SHL);
  endfunction

endpackage

// File: rtl/univ_shreg_seq_shreg_stage.sv
// One bit of the universal shift register: 4:1 next-value mux feeding an async-reset flop.
module shreg_stage
  import univ_shreg_seq_pkg::*;
(
  input  logic  clck,
  input  logic  reste,
  input  mode_e sel,
  input  logic  from_hi,
  input  logic  from_lo,
  input  logic  ld,
  output logic  q
);

  always_ff @(posedge clck or negedge reste) begin
    if (!reste) begin
      q <= 1'b0;
    end else begin
      case (sel)
        HOLD:    q <= q;
        SHR:     q <= from_hi;
        SHL:     q <= from_lo;
        LOAD:    q <= ld;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/univ_shreg_seq.sv
// Universal shift register with single-step modes plus an FSM-driven multi-bit shift
// (start/amt) reporting busy while shifting and a one-cycle done pulse.
module univ_shreg_seq
  import univ_shreg_seq_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clck,
  input  logic             reste,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] I,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             rot,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] A,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_left;
  logic             rot_q;

  mode_e            sel;
  logic             rot_eff;
  logic             fill_r;
  logic             fill_l;
  logic             shift_req;
  logic [CNT_W-1:0] amt_sat;
  logic [WIDTH-1:0] hi_vec;
  logic [WIDTH-1:0] lo_vec;

  // A launched request only latches parameters; the register itself holds on that edge.
  always_comb begin
    shift_req = start && is_shift_mode(mode);
    amt_sat   = (amt > WIDTH_C) ? WIDTH_C : amt;
    sel       = HOLD;
    rot_eff   = rot;
    case (state)
      IDLE:    sel = shift_req ? HOLD : mode_e'(mode);
      SHIFT: begin
        sel     = dir_left ? SHL : SHR;
        rot_eff = rot_q;
      end
      default: sel = HOLD;
    endcase
    fill_r = rot_eff ? A[0]       : sin_r;
    fill_l = rot_eff ? A[WIDTH-1] : sin_l;
    hi_vec = {fill_r, A[WIDTH-1:1]};
    lo_vec = {A[WIDTH-2:0], fill_l};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    shreg_stage u_stage (
      .clck    (clck),
      .reste   (reste),
      .sel     (sel),
      .from_hi (hi_vec[i]),
      .from_lo (lo_vec[i]),
      .ld      (I[i]),
      .q       (A[i])
    );
  end

  assign sout_r = A[0];
  assign sout_l = A[WIDTH-1];

  // busy/done are registered alongside the state so they track it exactly.
  always_ff @(posedge clck or negedge reste) begin
    if (!reste) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_left <= 1'b0;
      rot_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (shift_req) begin
            dir_left <= (mode == SHL);
            rot_q    <= rot;
            cnt      <= amt_sat;
            if (amt_sat != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
